cnn_train_sequencer: RTL and testbench

Training-loop controller for the single-clock CNN datapath (conv → maxpool → flatten → fully connected → softmax → cross-entropy).
- Drives the one-time random initialisation of conv kernels and FCL weight/bias rows from the LFSR word.
- Accepts training samples over a valid/ready handshake and sequences the softmax start/done handshake.
- Issues a single-cycle weight-commit strobe per sample, and counts samples until a programmed total is reached.
- Sits beside the datapath in the top level; replaces ad-hoc state logic there.

---
 rtl/cnn_train_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_cnn_train_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_train_sequencer.sv
// Training-loop sequencer for the CNN datapath: one-time random weight init,
// per-sample softmax handshake, weight-commit strobe and run-length counting.
module cnn_train_sequencer #(
  parameter int CHANNELS      = 10,
  parameter int FCL_INPUT_DIM = 1690,
  parameter int SETTLE_CYCLES = 2,
  parameter int SM_TIMEOUT    = 1024,
  parameter int CNT_W         = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               skip_init,
  input  logic [CNT_W-1:0]                   num_samples,
  input  logic                               sample_valid,
  output logic                               sample_ready,
  output logic                               input_load,
  output logic                               init_kernel_we,
  output logic [$clog2(CHANNELS)-1:0]        init_kernel_idx,
  output logic                               init_fcl_we,
  output logic [$clog2(FCL_INPUT_DIM+1)-1:0] init_fcl_idx,
  output logic                               softmax_start,
  input  logic                               softmax_done,
  output logic                               weight_update,
  output logic [CNT_W-1:0]                   sample_count,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout_err
);

  localparam int KIDX_W = $clog2(CHANNELS);
  localparam int FIDX_W = $clog2(FCL_INPUT_DIM + 1);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W  = (SM_TIMEOUT > 1) ? $clog2(SM_TIMEOUT) : 1;

  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(CHANNELS - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FCL_INPUT_DIM);
  localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    INIT_CONV   = 4'd1,
    INIT_FCL    = 4'd2,
    WAIT_SAMPLE = 4'd3,
    SETTLE      = 4'd4,
    SM_START    = 4'd5,
    SM_WAIT     = 4'd6,
    UPDATE      = 4'd7,
    FINISH      = 4'd8
  } state_e;

  state_e            state_r;
  state_e            state_next_s;
  logic [KIDX_W-1:0] kern_idx_r;
  logic [FIDX_W-1:0] fcl_idx_r;
  logic [SET_W-1:0]  settle_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [CNT_W-1:0]  num_r;
  logic [CNT_W-1:0]  count_r;
  logic              err_r;

  logic kern_last_s;
  logic fcl_last_s;
  logic tmo_last_s;
  logic run_full_s;

  assign kern_last_s = (kern_idx_r == KIDX_LAST);
  assign fcl_last_s  = (fcl_idx_r == FIDX_LAST);
  assign tmo_last_s  = (tmo_r == TMO_LAST);
  assign run_full_s  = ((count_r + CNT_W'(1)) == num_r);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Init indices, settle/timeout counters, run bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kern_idx_r <= KIDX_W'(0);
      fcl_idx_r  <= FIDX_W'(0);
      settle_r   <= SET_W'(0);
      tmo_r      <= TMO_W'(0);
      num_r      <= CNT_W'(0);
      count_r    <= CNT_W'(0);
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            num_r      <= num_samples;
            count_r    <= CNT_W'(0);
            err_r      <= 1'b0;
            kern_idx_r <= KIDX_W'(0);
            fcl_idx_r  <= FIDX_W'(0);
          end
        end
        INIT_CONV: begin
          kern_idx_r <= kern_last_s ? KIDX_W'(0) : (kern_idx_r + KIDX_W'(1));
        end
        INIT_FCL: begin
          fcl_idx_r <= fcl_last_s ? FIDX_W'(0) : (fcl_idx_r + FIDX_W'(1));
        end
        WAIT_SAMPLE: begin
          if (sample_valid) begin
            settle_r <= SET_LOAD;
          end
        end
        SETTLE: begin
          if (settle_r != SET_W'(0)) begin
            settle_r <= settle_r - SET_W'(1);
          end
        end
        SM_START: begin
          tmo_r <= TMO_W'(0);
        end
        SM_WAIT: begin
          // A completion arriving on the last allowed cycle still wins over the timeout
          if (!softmax_done) begin
            if (tmo_last_s) begin
              err_r <= 1'b1;
            end else begin
              tmo_r <= tmo_r + TMO_W'(1);
            end
          end
        end
        UPDATE: begin
          count_r <= count_r + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (skip_init) begin
            if (num_samples == CNT_W'(0)) begin
              state_next_s = FINISH;
            end else begin
              state_next_s = WAIT_SAMPLE;
            end
          end else begin
            state_next_s = INIT_CONV;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      INIT_CONV: begin
        if (kern_last_s) begin
          state_next_s = INIT_FCL;
        end else begin
          state_next_s = INIT_CONV;
        end
      end
      INIT_FCL: begin
        if (fcl_last_s) begin
          if (num_r == CNT_W'(0)) begin
            state_next_s = FINISH;
          end else begin
            state_next_s = WAIT_SAMPLE;
          end
        end else begin
          state_next_s = INIT_FCL;
        end
      end
      WAIT_SAMPLE: begin
        if (sample_valid) begin
          state_next_s = SETTLE;
        end else begin
          state_next_s = WAIT_SAMPLE;
        end
      end
      SETTLE: begin
        if (settle_r == SET_W'(0)) begin
          state_next_s = SM_START;
        end else begin
          state_next_s = SETTLE;
        end
      end
      SM_START: begin
        state_next_s = SM_WAIT;
      end
      SM_WAIT: begin
        if (softmax_done) begin
          state_next_s = UPDATE;
        end else if (tmo_last_s) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = SM_WAIT;
        end
      end
      UPDATE: begin
        if (run_full_s) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = WAIT_SAMPLE;
        end
      end
      FINISH: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode from registered state; only input_load sees an input directly
  always_comb begin
    sample_ready   = 1'b0;
    init_kernel_we = 1'b0;
    init_fcl_we    = 1'b0;
    softmax_start  = 1'b0;
    weight_update  = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;
    case (state_r)
      IDLE:        busy           = 1'b0;
      INIT_CONV:   init_kernel_we = 1'b1;
      INIT_FCL:    init_fcl_we    = 1'b1;
      WAIT_SAMPLE: sample_ready   = 1'b1;
      SM_START:    softmax_start  = 1'b1;
      UPDATE:      weight_update  = 1'b1;
      FINISH:      done           = 1'b1;
      default: begin
        busy = 1'b1;
      end
    endcase
    input_load = sample_valid & sample_ready;
  end

  assign init_kernel_idx = kern_idx_r;
  assign init_fcl_idx    = fcl_idx_r;
  assign sample_count    = count_r;
  assign timeout_err     = err_r;

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Self-checking bench for cnn_train_sequencer: timeline-based reference model
// compared every cycle, directed scenarios with literal pins, then random traffic.
module tb_cnn_train_sequencer;

  localparam int CH       = 10;
  localparam int FD       = 1690;
  localparam int SC       = 2;
  localparam int TMO      = 16;
  localparam int CW       = 16;
  localparam int INIT_LEN = CH + FD + 1;

  logic          clk          = 1'b0;
  logic          reset        = 1'b0;
  logic          start        = 1'b0;
  logic          skip_init    = 1'b0;
  logic [CW-1:0] num_samples  = '0;
  logic          sample_valid = 1'b0;
  logic          resp_done    = 1'b0;
  logic          spur_done    = 1'b0;
  logic          softmax_done;

  logic          sample_ready, input_load, init_kernel_we, init_fcl_we;
  logic [3:0]    init_kernel_idx;
  logic [10:0]   init_fcl_idx;
  logic          softmax_start, weight_update, busy, done, timeout_err;
  logic [CW-1:0] sample_count;

  assign softmax_done = resp_done | spur_done;

  cnn_train_sequencer #(
    .CHANNELS(CH), .FCL_INPUT_DIM(FD), .SETTLE_CYCLES(SC), .SM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .skip_init(skip_init),
    .num_samples(num_samples), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .input_load(input_load), .init_kernel_we(init_kernel_we), .init_kernel_idx(init_kernel_idx),
    .init_fcl_we(init_fcl_we), .init_fcl_idx(init_fcl_idx), .softmax_start(softmax_start),
    .softmax_done(softmax_done), .weight_update(weight_update), .sample_count(sample_count),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Event log of DUT activity for the directed literal checks
  int n_kwe, n_fwe, n_upd, n_done, n_ready, n_smst;
  int first_ready, done_cyc, smst_cyc, err_cyc;
  int upd_q[$];

  task automatic clear_log();
    n_kwe = 0; n_fwe = 0; n_upd = 0; n_done = 0; n_ready = 0; n_smst = 0;
    first_ready = -1; done_cyc = -1; smst_cyc = -1; err_cyc = -1;
    upd_q.delete();
  endtask

  // Reference model: a run is a timeline of phases; t counts cycles within a phase
  typedef enum int {M_IDLE, M_INIT, M_WAIT, M_PROC, M_FIN} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_t    = 0;
  int     m_num  = 0;
  int     m_cnt  = 0;
  bit     m_err  = 1'b0;
  bit     m_upd  = 1'b0;

  always @(negedge clk) begin
    int e_kwe, e_fwe, e_ready, e_smst, e_wu;
    if (!reset) begin
      m_mode = M_IDLE; m_t = 0; m_cnt = 0; m_err = 1'b0; m_upd = 1'b0; m_num = 0;
      chk("rst_busy",   32'(busy), 0);
      chk("rst_ready",  32'(sample_ready), 0);
      chk("rst_load",   32'(input_load), 0);
      chk("rst_kwe",    32'(init_kernel_we), 0);
      chk("rst_kidx",   32'(init_kernel_idx), 0);
      chk("rst_fwe",    32'(init_fcl_we), 0);
      chk("rst_fidx",   32'(init_fcl_idx), 0);
      chk("rst_smst",   32'(softmax_start), 0);
      chk("rst_wu",     32'(weight_update), 0);
      chk("rst_count",  32'(sample_count), 0);
      chk("rst_done",   32'(done), 0);
      chk("rst_err",    32'(timeout_err), 0);
    end else begin
      e_kwe   = (m_mode == M_INIT && m_t < CH) ? 1 : 0;
      e_fwe   = (m_mode == M_INIT && m_t >= CH) ? 1 : 0;
      e_ready = (m_mode == M_WAIT) ? 1 : 0;
      e_smst  = (m_mode == M_PROC && m_t == SC && !m_upd) ? 1 : 0;
      e_wu    = (m_mode == M_PROC && m_upd) ? 1 : 0;
      chk("busy",          32'(busy), (m_mode != M_IDLE) ? 1 : 0);
      chk("sample_ready",  32'(sample_ready), e_ready);
      chk("input_load",    32'(input_load), (e_ready != 0 && sample_valid) ? 1 : 0);
      chk("kernel_we",     32'(init_kernel_we), e_kwe);
      chk("fcl_we",        32'(init_fcl_we), e_fwe);
      chk("softmax_start", 32'(softmax_start), e_smst);
      chk("weight_update", 32'(weight_update), e_wu);
      chk("sample_count",  32'(sample_count), m_cnt);
      chk("done",          32'(done), (m_mode == M_FIN) ? 1 : 0);
      chk("timeout_err",   32'(timeout_err), 32'(m_err));
      if (e_kwe != 0) chk("kernel_idx", 32'(init_kernel_idx), m_t);
      if (e_fwe != 0) chk("fcl_idx", 32'(init_fcl_idx), m_t - CH);

      if (init_kernel_we) n_kwe++;
      if (init_fcl_we) n_fwe++;
      if (weight_update) begin n_upd++; upd_q.push_back(cyc); end
      if (done) begin n_done++; done_cyc = cyc; end
      if (sample_ready) begin n_ready++; if (first_ready < 0) first_ready = cyc; end
      if (softmax_start) begin n_smst++; smst_cyc = cyc; end
      if (timeout_err && err_cyc < 0) err_cyc = cyc;

      case (m_mode)
        M_IDLE: if (start) begin
          m_num = int'(num_samples); m_cnt = 0; m_err = 1'b0; m_t = 0;
          if (skip_init) m_mode = (m_num == 0) ? M_FIN : M_WAIT;
          else m_mode = M_INIT;
        end
        M_INIT: if (m_t == INIT_LEN - 1) begin
          m_mode = (m_num == 0) ? M_FIN : M_WAIT; m_t = 0;
        end else m_t++;
        M_WAIT: if (sample_valid) begin m_mode = M_PROC; m_t = 0; m_upd = 1'b0; end
        M_PROC: begin
          if (m_upd) begin
            m_cnt = (m_cnt + 1) % 65536; m_upd = 1'b0;
            m_mode = (m_cnt == m_num) ? M_FIN : M_WAIT;
          end else if (m_t > SC && softmax_done) m_upd = 1'b1;
          else if (m_t == SC + TMO) begin m_err = 1'b1; m_mode = M_FIN; end
          else m_t++;
        end
        M_FIN: m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Softmax responder: done pulse L cycles after the start cycle; L == 0 never answers
  int sm_lat   = 5;
  bit rand_lat = 1'b0;
  int resp_lat = 0;
  initial forever begin
    @(negedge clk);
    if (reset && softmax_start) begin
      if (rand_lat) begin
        resp_lat = int'($urandom_range(1, 20));
        if ($urandom_range(0, 7) == 0) resp_lat = 0;
      end else resp_lat = sm_lat;
      if (resp_lat > 0) begin
        repeat (resp_lat) @(posedge clk);
        #1 resp_done = 1'b1;
        @(posedge clk);
        #1 resp_done = 1'b0;
      end
    end
  end

  task automatic kick(input bit skip, input int num, output int t0);
    @(posedge clk); #1;
    clear_log();
    start = 1'b1; skip_init = skip; num_samples = CW'(num); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (n_done == 0 && k < budget) begin @(negedge clk); #1; k++; end
    if (n_done == 0) begin
      checks++; errors++;
      $display("FAIL %s: done not seen within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int t0;
    int k;
    clear_log();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset mid INIT_FCL at row 500
    sample_valid = 1'b1;
    kick(1'b0, 5, t0);
    k = 0;
    while (!(init_fcl_we && init_fcl_idx == 11'd500) && k < 800) begin @(negedge clk); k++; end
    chk("reach_fcl_500", 32'(init_fcl_idx), 500);
    #1 reset = 1'b0;
    #1;
    chk("async_busy",    32'(busy), 0);
    chk("async_fcl_we",  32'(init_fcl_we), 0);
    chk("async_fcl_idx", 32'(init_fcl_idx), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_no_done", n_done, 0);

    // Full init then one sample
    sm_lat = 5;
    kick(1'b0, 1, t0);
    wait_done(2000, "init_run");
    chk("init_kernel_writes", n_kwe, 10);
    chk("init_fcl_writes",    n_fwe, 1691);
    chk("init_first_ready",   first_ready - t0, 1702);
    chk("init_updates",       n_upd, 1);

    // Three back-to-back samples, L=5
    kick(1'b1, 3, t0);
    wait_done(200, "three_samples");
    chk("three_updates", n_upd, 3);
    if (upd_q.size() == 3) begin
      chk("upd_spacing_1", upd_q[1] - upd_q[0], 10);
      chk("upd_spacing_2", upd_q[2] - upd_q[1], 10);
      chk("done_after_upd", done_cyc - upd_q[2], 1);
    end
    chk("three_count", 32'(sample_count), 3);

    // Zero-sample run
    kick(1'b1, 0, t0);
    wait_done(20, "zero_run");
    chk("zero_done_cycle", done_cyc - t0, 1);
    chk("zero_no_ready",   n_ready, 0);
    chk("zero_no_update",  n_upd, 0);

    // Softmax never answers
    sm_lat = 0;
    kick(1'b1, 2, t0);
    wait_done(100, "timeout_run");
    chk("tmo_err_cycle",  err_cyc - smst_cyc, 17);
    chk("tmo_done_cycle", done_cyc - smst_cyc, 17);
    chk("tmo_no_update",  n_upd, 0);
    sm_lat = 3;
    kick(1'b1, 1, t0);
    @(negedge clk);
    chk("tmo_cleared", 32'(timeout_err), 0);
    wait_done(100, "after_timeout");

    // Spurious done while waiting for a sample, start while waiting for softmax
    sample_valid = 1'b0;
    sm_lat = 8;
    kick(1'b1, 1, t0);
    repeat (3) @(posedge clk);
    #1 spur_done = 1'b1;
    @(posedge clk); #1 spur_done = 1'b0; sample_valid = 1'b1;
    @(posedge clk); #1 sample_valid = 1'b0;
    k = 0;
    while (!softmax_start && k < 20) begin @(negedge clk); k++; end
    chk("spur_saw_start", 32'(softmax_start), 1);
    @(posedge clk); #1 start = 1'b1; num_samples = CW'(9);
    @(posedge clk); #1 start = 1'b0;
    wait_done(100, "spurious_run");
    chk("spur_updates", n_upd, 1);
    chk("spur_starts",  n_smst, 1);
    chk("spur_dones",   n_done, 1);
    chk("spur_count",   32'(sample_count), 1);

    // Random traffic
    rand_lat = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      reset        = ($urandom_range(0, 399) != 0);
      sample_valid = ($urandom_range(0, 9) < 7);
      spur_done    = ($urandom_range(0, 29) == 0);
      start        = ($urandom_range(0, 9) == 0);
      skip_init    = 1'b1;
      num_samples  = CW'($urandom_range(0, 4));
    end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; spur_done = 1'b0; sample_valid = 1'b0;
    repeat (40) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
